// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C register-file slave.
// Bus-level constants are the wire levels seen on SDA during the acknowledge bit.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK,
    IGNORE
  } state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a glitch filter: the filtered level only follows
// the synchronized level after FILTER_LEN consecutive equal samples. Idles high.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic filt
);

  logic       sync1;
  logic       sync2;
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= 4'd0;
      filt  <= 1'b1;
    end else begin
      sync1 <= line;
      sync2 <= sync1;
      // Any sample agreeing with the current filtered level restarts the run.
      if (sync2 == filt) begin
        cnt <= 4'd0;
      end else if (cnt == 4'(FILTER_LEN - 1)) begin
        filt <= sync2;
        cnt  <= 4'd0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave answering one 7-bit address and exposing a byte register file with an
// auto-incrementing pointer. Never stretches SCL; SDA is driven open-drain via SDA_PADOEN_O.
module i2c_slave_regfile
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         NUM_REGS   = 16,
  parameter int         FILTER_LEN = 3,
  localparam int        IDX_W      = $clog2(NUM_REGS)
) (
  input  logic             WB_CLK_I,
  input  logic             WB_RST_I,
  input  logic             SCL_PAD_I,
  input  logic             SDA_PAD_I,
  output logic             SDA_PAD_O,
  output logic             SDA_PADOEN_O,
  output logic             BUSY_O,
  output logic             WR_STB_O,
  output logic [IDX_W-1:0] WR_IDX_O,
  output logic [7:0]       WR_DATA_O,
  input  logic [IDX_W-1:0] DBG_IDX_I,
  output logic [7:0]       DBG_DATA_O,
  output logic [3:0]       DBG_STATE_O
);

  logic scl_f, sda_f, scl_d, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det, byte_done;

  state_e           state, state_next;
  logic [3:0]       bit_cnt, bit_cnt_next;
  logic [7:0]       shreg, shreg_next;
  logic [IDX_W-1:0] ptr, ptr_next;
  logic             sda_oen, oen_next;
  logic             busy, busy_next;
  logic             reg_we;
  logic             wr_stb, wr_stb_next;
  logic [IDX_W-1:0] wr_idx, wr_idx_next;
  logic [7:0]       wr_data, wr_data_next;
  logic [7:0]       regs [NUM_REGS];

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk  (WB_CLK_I),
    .rst  (WB_RST_I),
    .line (SCL_PAD_I),
    .filt (scl_f)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk  (WB_CLK_I),
    .rst  (WB_RST_I),
    .line (SDA_PAD_I),
    .filt (sda_f)
  );

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  // SCL must be high both before and after the SDA edge, so simultaneous settling of
  // both filters after reset can never fake a START or STOP.
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;
  assign byte_done = (bit_cnt == 4'(BITS_PER_BYTE));

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shreg_next   = shreg;
    ptr_next     = ptr;
    oen_next     = sda_oen;
    busy_next    = busy;
    reg_we       = 1'b0;
    wr_stb_next  = 1'b0;
    wr_idx_next  = wr_idx;
    wr_data_next = wr_data;

    if (start_det) begin
      state_next   = ADDR;
      bit_cnt_next = 4'd0;
      oen_next     = 1'b1;
      busy_next    = 1'b1;
    end else if (stop_det) begin
      state_next   = IDLE;
      bit_cnt_next = 4'd0;
      oen_next     = 1'b1;
      busy_next    = 1'b0;
    end else if (scl_rise) begin
      case (state)
        ADDR, PTR, WDATA, RACK: begin
          shreg_next   = {shreg[6:0], sda_f};
          bit_cnt_next = bit_cnt + 4'd1;
        end
        RDATA:   bit_cnt_next = bit_cnt + 4'd1;
        default: ;
      endcase
    end else if (scl_fall) begin
      // All SDA changes happen here, i.e. only while SCL is low.
      case (state)
        ADDR: if (byte_done) begin
          bit_cnt_next = 4'd0;
          if (shreg[7:1] == SLAVE_ADDR) begin
            state_next = ADDR_ACK;
            oen_next   = I2C_ACK;
          end else begin
            state_next = IGNORE;
          end
        end
        ADDR_ACK: begin
          bit_cnt_next = 4'd0;
          if (shreg[0]) begin
            state_next = RDATA;
            shreg_next = regs[ptr];
            oen_next   = regs[ptr][7];
          end else begin
            state_next = PTR;
            oen_next   = 1'b1;
          end
        end
        PTR: if (byte_done) begin
          bit_cnt_next = 4'd0;
          ptr_next     = shreg[IDX_W-1:0];
          oen_next     = I2C_ACK;
          state_next   = PTR_ACK;
        end
        PTR_ACK, WDATA_ACK: begin
          bit_cnt_next = 4'd0;
          oen_next     = 1'b1;
          state_next   = WDATA;
        end
        WDATA: if (byte_done) begin
          bit_cnt_next = 4'd0;
          reg_we       = 1'b1;
          wr_stb_next  = 1'b1;
          wr_idx_next  = ptr;
          wr_data_next = shreg;
          ptr_next     = ptr + IDX_W'(1);
          oen_next     = I2C_ACK;
          state_next   = WDATA_ACK;
        end
        RDATA: begin
          if (byte_done) begin
            bit_cnt_next = 4'd0;
            oen_next     = 1'b1;
            ptr_next     = ptr + IDX_W'(1);
            state_next   = RACK;
          end else begin
            oen_next   = shreg[6];
            shreg_next = {shreg[6:0], 1'b0};
          end
        end
        RACK: if (bit_cnt != 4'd0) begin
          bit_cnt_next = 4'd0;
          if (shreg[0] == I2C_NACK) begin
            state_next = IGNORE;
          end else begin
            state_next = RDATA;
            shreg_next = regs[ptr];
            oen_next   = regs[ptr][7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge WB_CLK_I or posedge WB_RST_I) begin
    if (WB_RST_I) begin
      state   <= IDLE;
      bit_cnt <= 4'd0;
      shreg   <= 8'd0;
      ptr     <= '0;
      sda_oen <= 1'b1;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_idx  <= '0;
      wr_data <= 8'd0;
      scl_d   <= 1'b1;
      sda_d   <= 1'b1;
    end else begin
      state   <= state_next;
      bit_cnt <= bit_cnt_next;
      shreg   <= shreg_next;
      ptr     <= ptr_next;
      sda_oen <= oen_next;
      busy    <= busy_next;
      wr_stb  <= wr_stb_next;
      wr_idx  <= wr_idx_next;
      wr_data <= wr_data_next;
      scl_d   <= scl_f;
      sda_d   <= sda_f;
    end
  end

  always_ff @(posedge WB_CLK_I or posedge WB_RST_I) begin
    if (WB_RST_I) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'd0;
    end else if (reg_we) begin
      regs[ptr] <= shreg;
    end
  end

  // WR_STB_O is a valid-only strobe: WR_IDX_O/WR_DATA_O are meaningful in the strobe
  // cycle and there is no ready, so the consumer must take the byte in that cycle.
  assign WR_STB_O     = wr_stb;
  assign WR_IDX_O     = wr_idx;
  assign WR_DATA_O    = wr_data;
  assign SDA_PAD_O    = 1'b0;
  assign SDA_PADOEN_O = sda_oen;
  assign BUSY_O       = busy;
  assign DBG_DATA_O   = regs[DBG_IDX_I];
  assign DBG_STATE_O  = state;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a bit-level I2C master model on an open-drain
// SDA wire, a write-strobe scoreboard and backdoor register checks.
module tb_i2c_slave_regfile;
  import i2c_slave_pkg::*;

  localparam int NUM_REGS = 16;
  localparam int IDX_W    = 4;
  localparam int W        = IDX_W + 8;
  localparam int Q        = 20;  // quarter SCL period in clk cycles

  logic             clk = 1'b0;
  logic             rst;
  logic             scl_m, sda_m, sda_line;
  logic             sda_pad_o, sda_padoen_o, busy_o, wr_stb_o;
  logic [IDX_W-1:0] wr_idx_o, dbg_idx;
  logic [7:0]       wr_data_o, dbg_data_o;
  logic [3:0]       dbg_state_o;

  int         tests = 0;
  int         fails = 0;
  logic [W-1:0] exp_q[$];
  logic       watch_oen = 1'b0;
  int         oen_low_cnt = 0;

  // clock / reset
  always #5 clk = ~clk;

  assign sda_line = sda_m & (sda_padoen_o | sda_pad_o);

  i2c_slave_regfile #(
    .SLAVE_ADDR (7'h50),
    .NUM_REGS   (NUM_REGS),
    .FILTER_LEN (3)
  ) dut (
    .WB_CLK_I     (clk),
    .WB_RST_I     (rst),
    .SCL_PAD_I    (scl_m),
    .SDA_PAD_I    (sda_line),
    .SDA_PAD_O    (sda_pad_o),
    .SDA_PADOEN_O (sda_padoen_o),
    .BUSY_O       (busy_o),
    .WR_STB_O     (wr_stb_o),
    .WR_IDX_O     (wr_idx_o),
    .WR_DATA_O    (wr_data_o),
    .DBG_IDX_I    (dbg_idx),
    .DBG_DATA_O   (dbg_data_o),
    .DBG_STATE_O  (dbg_state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every strobe must match the head of exp_q; with nothing expected the
  // reference is all-x, which no driven strobe can equal.
  always @(negedge clk) begin
    if (wr_stb_o) begin
      if (exp_q.size() > 0) check("wr_stb", {wr_idx_o, wr_data_o}, 32'(exp_q.pop_front()));
      else                  check("wr_stb_unexpected", {wr_idx_o, wr_data_o}, 'x);
    end
    if (watch_oen && !sda_padoen_o) oen_low_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    sda_m = b; wait_clk(Q);
    scl_m = 1'b1;
    if (glitch) begin
      wait_clk(Q);
      scl_m = 1'b0; wait_clk(2);
      scl_m = 1'b1; wait_clk(Q - 2);
    end else begin
      wait_clk(2 * Q);
    end
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    b = sda_line; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_bit);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack_send, output logic [7:0] d);
    logic b;
    d = 8'd0;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(ack_send, 1'b0);
  endtask

  task automatic send(input string tag, input logic [7:0] d, input logic exp_ack);
    logic ack;
    write_byte(d, -1, ack);
    check(tag, ack, exp_ack);
  endtask

  task automatic check_reg(input string tag, input logic [IDX_W-1:0] idx, input logic [7:0] exp);
    dbg_idx = idx; #1;
    check(tag, dbg_data_o, exp);
  endtask

  initial begin
    logic [7:0] d;
    logic       ack;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; dbg_idx = '0;
    wait_clk(3);
    check("rst_oen", sda_padoen_o, 1);
    check("rst_pad_o", sda_pad_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_wr_stb", wr_stb_o, 0);
    check("rst_wr_idx", wr_idx_o, 0);
    check("rst_wr_data", wr_data_o, 0);
    check("rst_state", dbg_state_o, IDLE);
    check("rst_reg0", dbg_data_o, 0);
    rst = 1'b0;
    wait_clk(10);

    // write two bytes from pointer 3
    i2c_start();
    check("wr_busy_start", busy_o, 1);
    send("wr_addr_ack", 8'hA0, 0);
    send("wr_ptr_ack", 8'h03, 0);
    exp_q.push_back({4'd3, 8'h5A});
    send("wr_d0_ack", 8'h5A, 0);
    exp_q.push_back({4'd4, 8'hC3});
    send("wr_d1_ack", 8'hC3, 0);
    i2c_stop();
    check("wr_busy_stop", busy_o, 0);
    check_reg("wr_reg3", 4'd3, 8'h5A);
    check_reg("wr_reg4", 4'd4, 8'hC3);

    // read back through a repeated START
    i2c_start();
    send("rd_addr_w_ack", 8'hA0, 0);
    send("rd_ptr_ack", 8'h03, 0);
    i2c_start();
    send("rd_addr_r_ack", 8'hA1, 0);
    read_byte(1'b0, d);
    check("rd_byte0", d, 8'h5A);
    read_byte(1'b1, d);
    check("rd_byte1", d, 8'hC3);
    check("rd_oen_after_nack", sda_padoen_o, 1);
    i2c_stop();

    // foreign address: never drives SDA, never writes
    oen_low_cnt = 0;
    watch_oen = 1'b1;
    i2c_start();
    check("fa_busy_start", busy_o, 1);
    send("fa_addr_nack", 8'h42, 1);
    send("fa_data_nack", 8'h00, 1);
    check("fa_busy_mid", busy_o, 1);
    i2c_stop();
    watch_oen = 1'b0;
    check("fa_oen_low_cycles", oen_low_cnt, 0);
    check("fa_busy_stop", busy_o, 0);

    // pointer 0x1F wraps to 15, then the increment wraps to 0
    i2c_start();
    send("wrap_addr_ack", 8'hA0, 0);
    send("wrap_ptr_ack", 8'h1F, 0);
    exp_q.push_back({4'd15, 8'h11});
    send("wrap_d0_ack", 8'h11, 0);
    exp_q.push_back({4'd0, 8'h22});
    send("wrap_d1_ack", 8'h22, 0);
    i2c_stop();
    check_reg("wrap_reg15", 4'd15, 8'h11);
    check_reg("wrap_reg0", 4'd0, 8'h22);

    // 2-cycle SCL glitch inside bit 3 of a data byte
    i2c_start();
    send("gl_addr_ack", 8'hA0, 0);
    send("gl_ptr_ack", 8'h07, 0);
    exp_q.push_back({4'd7, 8'h96});
    write_byte(8'h96, 3, ack);
    check("gl_data_ack", ack, 0);
    i2c_stop();
    check_reg("gl_reg7", 4'd7, 8'h96);
    check_reg("gl_reg8", 4'd8, 8'h00);

    // repeated START after 4 data bits: no write, pointer stays 10
    i2c_start();
    send("ab_addr_ack", 8'hA0, 0);
    send("ab_ptr_ack", 8'h0A, 0);
    exp_q.push_back({4'd10, 8'h3C});
    send("ab_d0_ack", 8'h3C, 0);
    exp_q.push_back({4'd11, 8'h77});
    send("ab_d1_ack", 8'h77, 0);
    i2c_start();
    send("ab_addr2_ack", 8'hA0, 0);
    send("ab_ptr2_ack", 8'h0A, 0);
    write_bit(1'b1, 1'b0);
    write_bit(1'b0, 1'b0);
    write_bit(1'b1, 1'b0);
    write_bit(1'b1, 1'b0);
    i2c_start();
    send("ab_addr_r_ack", 8'hA1, 0);
    read_byte(1'b1, d);
    check("ab_read_ptr10", d, 8'h3C);
    i2c_stop();
    check_reg("ab_reg10", 4'd10, 8'h3C);
    check_reg("ab_reg11", 4'd11, 8'h77);
    check_reg("ab_reg12", 4'd12, 8'h00);

    // reset while the slave drives bit 7 (0) of reg10
    i2c_start();
    send("rr_addr_ack", 8'hA0, 0);
    send("rr_ptr_ack", 8'h0A, 0);
    i2c_start();
    send("rr_addr_r_ack", 8'hA1, 0);
    check("rr_driving_zero", sda_padoen_o, 0);
    rst = 1'b1; #1;
    check("rr_async_oen", sda_padoen_o, 1);
    check("rr_busy", busy_o, 0);
    for (int i = 0; i < NUM_REGS; i++) check_reg("rr_reg_zero", IDX_W'(i), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    wait_clk(10);
    i2c_stop();
    i2c_start();
    send("rr2_addr_ack", 8'hA0, 0);
    send("rr2_ptr_ack", 8'h02, 0);
    exp_q.push_back({4'd2, 8'hE7});
    send("rr2_d0_ack", 8'hE7, 0);
    i2c_start();
    send("rr2_addr_w_ack", 8'hA0, 0);
    send("rr2_ptr2_ack", 8'h02, 0);
    i2c_start();
    send("rr2_addr_r_ack", 8'hA1, 0);
    read_byte(1'b1, d);
    check("rr2_read", d, 8'hE7);
    i2c_stop();
    check_reg("rr2_reg2", 4'd2, 8'hE7);

    wait_clk(5);
    check("wr_queue_empty", exp_q.size(), 0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
